// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Holds the FSM state encoding, default adder latency and counter sizing helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned ADD_LAT_DEF = 2;

  // Width of a counter that must reach lat (counts 0..lat)
  function automatic int unsigned phase_w(input int unsigned lat);
    return (lat < 32'd1) ? 32'd1 : 32'($clog2(lat + 32'd1));
  endfunction

endpackage

// File: rtl/full_adder_reg.sv
// Registered 1-bit full adder: input register stage followed by an output register stage.
// Two clocks from a/b/cin to sum/cout; active-high asynchronous reset.
module full_adder_reg (
  input  logic clock,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic a_q;
  logic b_q;
  logic cin_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q   <= 1'b0;
      b_q   <= 1'b0;
      cin_q <= 1'b0;
      sum   <= 1'b0;
      cout  <= 1'b0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      cin_q <= cin;
      sum   <= a_q ^ b_q ^ cin_q;
      cout  <= (a_q & b_q) | (a_q & cin_q) | (b_q & cin_q);
    end
  end

endmodule

// File: rtl/serial_shift_unit.sv
// Operand PISO registers and result SIPO register for the bit-serial adder.
// Bit 0 of each operand is driven straight to the adder, so only the upper bits are held here.
module serial_shift_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-2:0] a_in,
  input  logic [WIDTH-2:0] b_in,
  input  logic             sum_bit,
  output logic             a_next,
  output logic             b_next,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-2:0] a_sr;
  logic [WIDTH-2:0] b_sr;

  assign a_next = a_sr[0];
  assign b_next = b_sr[0];

  // Sum bits arrive LSB first and enter at the top, so after WIDTH shifts bit 0 sits at the bottom
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      result <= '0;
    end else if (load) begin
      a_sr   <= a_in;
      b_sr   <= b_in;
      result <= '0;
    end else if (shift) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      result <= {sum_bit, result[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_add_seq.sv
// Sequencer/collector around a registered 1-bit full adder: feeds operands LSB first,
// loops carry-out back to carry-in, and returns {cout,sum} over a valid/ready handshake.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ADD_LAT = ADD_LAT_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             add_a,
  output logic             add_b,
  output logic             add_cin,
  input  logic             add_sum,
  input  logic             add_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             busy
);

  localparam int unsigned PW = phase_w(ADD_LAT);
  localparam int unsigned IW = $clog2(WIDTH);

  state_e          state;
  state_e          state_next;
  logic [PW-1:0]   phase;
  logic [IW-1:0]   idx;
  logic            load;
  logic            shift;
  logic            last;
  logic            a_next;
  logic            b_next;

  assign last = (idx == IW'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // op_ready is implied by being in IDLE; the adder result is only trusted at the last phase
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    unique case (state)
      IDLE: begin
        if (op_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (phase == PW'(ADD_LAT)) begin
          shift = 1'b1;
          if (last) state_next = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_ready  <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      op_ready  <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
      res_valid <= (state_next == DONE);
    end
  end

  // Adder inputs stay stable for a whole bit period; carry feeds back at each sample edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= '0;
      idx      <= '0;
      add_a    <= 1'b0;
      add_b    <= 1'b0;
      add_cin  <= 1'b0;
      res_cout <= 1'b0;
    end else if (load) begin
      phase   <= '0;
      idx     <= '0;
      add_a   <= op_a[0];
      add_b   <= op_b[0];
      add_cin <= op_cin;
    end else if (state == RUN) begin
      if (shift) begin
        phase    <= '0;
        idx      <= idx + IW'(1);
        res_cout <= add_cout;
        if (last) begin
          add_a   <= 1'b0;
          add_b   <= 1'b0;
          add_cin <= 1'b0;
        end else begin
          add_a   <= a_next;
          add_b   <= b_next;
          add_cin <= add_cout;
        end
      end else begin
        phase <= phase + PW'(1);
      end
    end
  end

  serial_shift_unit #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .a_in    (op_a[WIDTH-1:1]),
    .b_in    (op_b[WIDTH-1:1]),
    .sum_bit (add_sum),
    .a_next  (a_next),
    .b_next  (b_next),
    .result  (res_sum)
  );

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq with the registered full adder attached; directed and random operands
// checked against plain integer addition.
module tb_serial_add_seq;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [7:0] op_a = 8'h00;
  logic [7:0] op_b = 8'h00;
  logic       op_cin = 1'b0;
  logic       add_a;
  logic       add_b;
  logic       add_cin;
  logic       add_sum;
  logic       add_cout;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_sum;
  logic       res_cout;
  logic       busy;
  logic       adder_rst;

  int checks = 0;
  int errors = 0;

  assign adder_rst = ~reset_n;

  always #5 clock = ~clock;

  serial_add_seq #(.WIDTH(8), .ADD_LAT(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .busy      (busy)
  );

  full_adder_reg u_adder (
    .clock (clock),
    .reset (adder_rst),
    .a     (add_a),
    .b     (add_b),
    .cin   (add_cin),
    .sum   (add_sum),
    .cout  (add_cout)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_op_ready"},  32'(op_ready),  32'd1);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_sum"},   32'(res_sum),   32'd0);
    check({tag, "_res_cout"},  32'(res_cout),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_add_bits"},  32'({add_a, add_b, add_cin}), 32'd0);
  endtask

  // Carry entering bit k of a+b+cin, from plain integer arithmetic
  function automatic logic carry_into(input logic [7:0] a, input logic [7:0] b, input logic cin, input int k);
    int mask;
    mask = (1 << k) - 1;
    return 1'((((int'(a) & mask) + (int'(b) & mask) + int'(cin)) >> k) & 1);
  endfunction

  // Called one time unit after a clock edge with the DUT idle
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input int hold, input bit inject);
    logic [8:0] expv;
    int         cnt;
    bit         done;
    int         k;
    expv = 9'(a) + 9'(b) + 9'(cin);
    check("idle_op_ready", 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op_a = a;
    op_b = b;
    op_cin = cin;
    @(posedge clock); #1;
    op_valid = 1'b0;
    op_a = 8'($urandom);
    op_b = 8'($urandom);
    op_cin = 1'($urandom);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_op_ready", 32'(op_ready), 32'd0);
    check("bit0_inputs", 32'({add_a, add_b, add_cin}), 32'({a[0], b[0], cin}));
    cnt = 0;
    done = 1'b0;
    while (!done && cnt < 200) begin
      if (inject && cnt == 9) begin
        op_valid = 1'b1;
        op_a = ~a;
        op_b = 8'h11;
        op_cin = ~cin;
      end
      @(posedge clock); #1;
      cnt++;
      if (inject && cnt == 10) begin
        check("inject_op_ready", 32'(op_ready), 32'd0);
        op_valid = 1'b0;
      end
      if (res_valid) begin
        done = 1'b1;
      end else if (cnt % 3 == 0) begin
        k = cnt / 3;
        check("bit_a",   32'(add_a),   32'(a[k]));
        check("bit_b",   32'(add_b),   32'(b[k]));
        check("bit_cin", 32'(add_cin), 32'(carry_into(a, b, cin, k)));
      end
    end
    check("latency",      32'(cnt),      32'd24);
    check("res_sum",      32'(res_sum),  32'(expv[7:0]));
    check("res_cout",     32'(res_cout), 32'(expv[8]));
    check("done_ready",   32'(op_ready), 32'd0);
    check("done_adder_in", 32'({add_a, add_b, add_cin}), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check("hold_valid",    32'(res_valid), 32'd1);
      check("hold_sum",      32'(res_sum),   32'(expv[7:0]));
      check("hold_cout",     32'(res_cout),  32'(expv[8]));
      check("hold_op_ready", 32'(op_ready),  32'd0);
    end
    res_ready = 1'b1;
    @(posedge clock); #1;
    res_ready = 1'b0;
    check("release_valid",    32'(res_valid), 32'd0);
    check("release_op_ready", 32'(op_ready),  32'd1);
    check("release_busy",     32'(busy),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;

    // res_ready without a pending result does nothing
    res_ready = 1'b1;
    @(posedge clock); #1;
    res_ready = 1'b0;
    check("stray_ready_op_ready", 32'(op_ready),  32'd1);
    check("stray_ready_valid",    32'(res_valid), 32'd0);

    run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    run_op(8'h12, 8'h34, 1'b1, 10, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 0, 1'b0);
    run_op(8'h0F, 8'hF0, 1'b1, 0, 1'b1);

    // Reset in the middle of bit 4
    op_valid = 1'b1;
    op_a = 8'hAA;
    op_b = 8'h55;
    op_cin = 1'b0;
    @(posedge clock); #1;
    op_valid = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_op(8'h01, 8'h01, 1'b0, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
